mem_debug_bridge: RTL

// - Debug bus initiator: decodes a host command byte stream (from a UART RX FIFO) into word reads/writes on the SoC data bus.
// - Returns read data and acks as a byte stream to a UART TX path.
// - Sits beside the CPU as a second bus master. The SoC bus mux gives the bridge the bus while bus_gnt=1.
// - Used for loading RAM at 0x80000000 and peeking/poking the UART/CLINT/PLIC space without firmware.

---
 rtl/mem_debug_bridge.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_debug_bridge.sv
// mem_debug_bridge: host byte-stream to SoC data-bus debug initiator.
// Frames: CMD(01=write/02=read), A0..A3, [D0..D3], all little-endian.
// Replies: ACK_BYTE after a write, 4 read bytes LSB first, ERR_BYTE on a bad command.
// Optional feature: define BRIDGE_TIMEOUT_EN to abandon partial frames after
// TIMEOUT_CYCLES idle cycles in ADDR/WDATA.
module mem_debug_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_REQ,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_is_wr;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_overrun;
  logic        w_tx_fire;
  logic        w_cmd_ok;
  logic        w_timeout;
  logic [4:0]  w_bidx;

  assign w_tx_fire = tx_valid && tx_ready;
  assign w_cmd_ok  = (rx_data == 8'h01) || (rx_data == 8'h02);
  assign w_bidx    = {r_cnt, 3'b000};

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;

`ifdef BRIDGE_TIMEOUT_EN
  logic [31:0] r_tmo;

  // Inter-byte timer: restarts on every byte and on entry to ADDR/WDATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (rx_valid ||
                 ((w_next != r_state) && ((w_next == S_ADDR) || (w_next == S_WDATA)))) begin
      r_tmo <= '0;
    end else if ((r_state == S_ADDR) || (r_state == S_WDATA)) begin
      r_tmo <= r_tmo + 32'd1;
    end else begin
      r_tmo <= '0;
    end
  end

  assign w_timeout = (r_tmo == 32'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and bus/TX outputs (all derived from the current state).
  always_comb begin
    w_next    = r_state;
    bus_req   = 1'b0;
    mem_wstrb = '0;
    mem_rstrb = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          w_next = w_cmd_ok ? S_ADDR : S_ERR;
        end
      end
      S_ADDR: begin
        if (rx_valid && (r_cnt == 2'd3)) begin
          w_next = r_is_wr ? S_WDATA : S_REQ;
        end else if (!rx_valid && w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_WDATA: begin
        if (rx_valid && (r_cnt == 2'd3)) begin
          w_next = S_REQ;
        end else if (!rx_valid && w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        bus_req = 1'b1;
        if (r_is_wr) begin
          mem_wstrb = 4'hF;
        end else begin
          mem_rstrb = 1'b1;
        end
        w_next = S_RESP;
      end
      S_RESP: begin
        tx_valid = 1'b1;
        tx_data  = r_is_wr ? ACK_BYTE : r_rdata[w_bidx +: 8];
        if (w_tx_fire && (r_is_wr || (r_cnt == 2'd3))) begin
          w_next = S_IDLE;
        end
      end
      S_ERR: begin
        tx_valid = 1'b1;
        tx_data  = ERR_BYTE;
        if (w_tx_fire) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: opcode, byte counter, address/data assembly, read capture, overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_wr   <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (rx_valid && ((r_state == S_REQ) || (r_state == S_ACCESS) ||
                       (r_state == S_RESP) || (r_state == S_ERR))) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (rx_valid && w_cmd_ok) begin
            r_is_wr <= (rx_data == 8'h01);
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            // Low address bits are cleared as they arrive so mem_addr is always word aligned.
            r_addr[w_bidx +: 8] <= (r_cnt == 2'd0) ? {rx_data[7:2], 2'b00} : rx_data;
            r_cnt               <= r_cnt + 2'd1;
          end else if (w_timeout) begin
            r_cnt <= '0;
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            r_wdata[w_bidx +: 8] <= rx_data;
            r_cnt                <= r_cnt + 2'd1;
          end else if (w_timeout) begin
            r_cnt <= '0;
          end
        end
        S_ACCESS: begin
          r_cnt <= '0;
          if (!r_is_wr) begin
            r_rdata <= mem_rdata;
          end
        end
        S_RESP: begin
          if (w_tx_fire) begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
